gdma_rst_seq: RTL and testbench

GDMA-domain reset sequencer that arbitrates reset requests from the host (asynchronous level flag), software (pulse) and watchdog (pulse) and applies them to the GDMA datapath in a safe order. It first stops and drains the DMA engine, then asserts the datapath reset for a fixed length. It holds the engine stopped for a release gap and reports completion. It sits between the host/CSR/watchdog logic and the GDMA datapath reset input, all in `gdma_clk`.

---
 rtl/gdma_rst_seq.sv | 116 +++++++++++
 tb/tb_gdma_rst_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gdma_rst_seq.sv
// GDMA-domain reset sequencer: merges host/sw/watchdog reset requests, drains the DMA
// engine, pulses the datapath reset, then holds the engine stopped for a release gap.
module gdma_rst_seq #(
    parameter int RST_LEN  = 9,
    parameter int DRAIN_TO = 255,
    parameter int GAP      = 4
) (
    input  logic       gdma_clk,
    input  logic       gdma_rst_n,
    input  logic       host_rst_flag,
    input  logic       sw_rst_req,
    input  logic       wdt_rst_req,
    input  logic       dma_idle,
    output logic       dma_stop,
    output logic       h2gdma_rst,
    output logic       rst_busy,
    output logic       rst_done,
    output logic [2:0] rst_cause,
    output logic       rst_to
);
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ASSERT, S_GAP} state_e;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TO - 1);
    localparam logic [7:0] RST_LAST   = 8'(RST_LEN - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] pend_q, pend_d;
    logic [2:0] cause_q, cause_d;
    logic       to_q, to_d;
    logic       done_q, done_d;
    logic       s0_q, s1_q;
    logic [2:0] req;

    // Host flag is asynchronous; a rising edge seen after the first stage is a request.
    always_ff @(posedge gdma_clk or negedge gdma_rst_n) begin
        if (!gdma_rst_n) begin
            s0_q <= 1'b0;
            s1_q <= 1'b0;
        end else begin
            s0_q <= host_rst_flag;
            s1_q <= s0_q;
        end
    end

    assign req = {wdt_rst_req, sw_rst_req, s0_q & ~s1_q};

    always_ff @(posedge gdma_clk or negedge gdma_rst_n) begin
        if (!gdma_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            cause_q <= '0;
            to_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            cause_q <= cause_d;
            to_q    <= to_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cause_d = cause_q;
        to_d    = to_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q != 3'b000) begin
                    state_d = S_DRAIN;
                    cause_d = pend_q | req;
                    pend_d  = 3'b000;
                    to_d    = 1'b0;
                end else begin
                    pend_d = pend_q | req;
                end
            end
            S_DRAIN: begin
                // Requests before the datapath reset is applied are covered by this sequence.
                cause_d = cause_q | req;
                if (dma_idle) begin
                    state_d = S_ASSERT;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = S_ASSERT;
                    to_d    = 1'b1;
                end
            end
            S_ASSERT: begin
                pend_d = pend_q | req;
                if (cnt_q == RST_LAST) state_d = S_GAP;
            end
            S_GAP: begin
                pend_d = pend_q | req;
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    end

    assign dma_stop   = (state_q != S_IDLE);
    assign h2gdma_rst = (state_q == S_ASSERT);
    assign rst_busy   = (state_q != S_IDLE);
    assign rst_done   = done_q;
    assign rst_cause  = cause_q;
    assign rst_to     = to_q;
endmodule

// File: tb/tb_gdma_rst_seq.sv
// Bench for gdma_rst_seq: directed scenarios plus random traffic against a timeline model.
module tb_gdma_rst_seq;
    localparam int RST_LEN  = 9;
    localparam int DRAIN_TO = 255;
    localparam int GAP      = 4;

    logic       gdma_clk = 1'b0;
    logic       gdma_rst_n = 1'b0;
    logic       host_rst_flag = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       wdt_rst_req = 1'b0;
    logic       dma_idle = 1'b1;
    logic       dma_stop, h2gdma_rst, rst_busy, rst_done, rst_to;
    logic [2:0] rst_cause;

    gdma_rst_seq #(.RST_LEN(RST_LEN), .DRAIN_TO(DRAIN_TO), .GAP(GAP)) dut (
        .gdma_clk(gdma_clk), .gdma_rst_n(gdma_rst_n), .host_rst_flag(host_rst_flag),
        .sw_rst_req(sw_rst_req), .wdt_rst_req(wdt_rst_req), .dma_idle(dma_idle),
        .dma_stop(dma_stop), .h2gdma_rst(h2gdma_rst), .rst_busy(rst_busy),
        .rst_done(rst_done), .rst_cause(rst_cause), .rst_to(rst_to)
    );

    always #5 gdma_clk = ~gdma_clk;

    int errors = 0;
    int checks = 0;

    // Timeline model: a sequence is described by the edge it started on and the edge
    // its reset pulse began; everything else follows from the lengths.
    int         n = 0;
    bit         m_active;
    int         m_dstart, m_astart;
    logic [2:0] m_pend, m_cause;
    logic       m_to, m_done, hs0, hs1;

    function automatic void model_reset();
        m_active = 0; m_dstart = 0; m_astart = -1;
        m_pend = 0; m_cause = 0; m_to = 0; m_done = 0; hs0 = 0; hs1 = 0;
    endfunction

    function automatic void model_step();
        logic [2:0] r;
        n++;
        r = {wdt_rst_req, sw_rst_req, hs0 & ~hs1};
        hs1 = hs0;
        hs0 = host_rst_flag;
        m_done = 0;
        if (!m_active) begin
            if (m_pend != 0) begin
                m_active = 1; m_dstart = n; m_astart = -1;
                m_cause = m_pend | r; m_pend = 0; m_to = 0;
            end else m_pend |= r;
        end else if (m_astart < 0) begin
            m_cause |= r;
            if (dma_idle || (n - m_dstart) == DRAIN_TO) begin
                m_astart = n;
                m_to = !dma_idle;
            end
        end else begin
            m_pend |= r;
            if ((n - m_astart) == RST_LEN + GAP) begin
                m_active = 0; m_done = 1;
            end
        end
    endfunction

    function automatic logic [7:0] model_outs();
        logic h2;
        h2 = m_active && (m_astart >= 0) && ((n - m_astart) < RST_LEN);
        return {m_active, h2, m_active, m_done, m_cause, m_to};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge gdma_clk);
        model_step();
        @(negedge gdma_clk);
        chk("outs", {dma_stop, h2gdma_rst, rst_busy, rst_done, rst_cause, rst_to}, model_outs());
    endtask

    initial begin
        int h2n, busyn, first, donek, drainn, dones;
        bit seen, stop1;
        model_reset();
        #1;
        chk("reset_outs", {dma_stop, h2gdma_rst, rst_busy, rst_done, rst_cause, rst_to}, 8'h00);
        @(negedge gdma_clk);
        @(negedge gdma_clk);
        #2 gdma_rst_n = 1'b1;
        @(negedge gdma_clk);
        for (int i = 0; i < 5; i++) tick();

        // sw pulse, idle engine
        sw_rst_req = 1; tick(); sw_rst_req = 0;
        h2n = 0; busyn = 0; first = -1; donek = -1; stop1 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) stop1 = dma_stop;
            if (h2gdma_rst) begin h2n++; if (first < 0) first = k; end
            if (rst_busy) busyn++;
            if (rst_done) donek = k;
        end
        chk("sw_stop_e1", stop1, 1);
        chk("sw_h2_first", first, 2);
        chk("sw_h2_len", h2n, RST_LEN);
        chk("sw_busy_len", busyn, 14);
        chk("sw_done_edge", donek, 15);
        chk("sw_cause", rst_cause, 3'b010);
        chk("sw_to", rst_to, 0);

        // host level held high: exactly one sequence
        host_rst_flag = 1; dones = 0;
        for (int k = 0; k < 40; k++) begin tick(); if (rst_done) dones++; end
        chk("host_dones", dones, 1);
        chk("host_cause", rst_cause, 3'b001);
        host_rst_flag = 0;
        for (int k = 0; k < 5; k++) tick();

        // wdt with engine never idle: drain timeout
        dma_idle = 0; wdt_rst_req = 1; tick(); wdt_rst_req = 0;
        drainn = 0; h2n = 0; seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            tick();
            if (dma_stop && !h2gdma_rst && h2n == 0) drainn++;
            if (h2gdma_rst) h2n++;
            if (rst_done) seen = 1;
        end
        chk("to_done_seen", seen, 1);
        chk("to_drain_len", drainn, DRAIN_TO);
        chk("to_h2_len", h2n, RST_LEN);
        chk("to_flag", rst_to, 1);
        chk("to_cause", rst_cause, 3'b100);
        dma_idle = 1;
        for (int k = 0; k < 3; k++) tick();

        // sw pulse during a host-started drain is absorbed
        dma_idle = 0; host_rst_flag = 1; seen = 0;
        for (int k = 0; k < 10 && !rst_busy; k++) tick();
        chk("mix_started", rst_busy, 1);
        sw_rst_req = 1; tick(); sw_rst_req = 0;
        tick(); dma_idle = 1;
        for (int k = 0; k < 50 && !seen; k++) begin tick(); if (rst_done) seen = 1; end
        chk("mix_done_seen", seen, 1);
        chk("mix_cause", rst_cause, 3'b011);
        busyn = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (rst_busy) busyn++; end
        chk("mix_no_second", busyn, 0);
        host_rst_flag = 0;
        for (int k = 0; k < 4; k++) tick();

        // wdt during ASSERT: back-to-back sequence
        sw_rst_req = 1; tick(); sw_rst_req = 0;
        for (int k = 0; k < 10 && !h2gdma_rst; k++) tick();
        chk("b2b_in_assert", h2gdma_rst, 1);
        wdt_rst_req = 1; tick(); wdt_rst_req = 0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin tick(); if (rst_done) seen = 1; end
        chk("b2b_first_done", seen, 1);
        tick();
        chk("b2b_busy", rst_busy, 1);
        chk("b2b_cause", rst_cause, 3'b100);
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin tick(); if (rst_done) seen = 1; end
        chk("b2b_second_done", seen, 1);

        // simultaneous sw + wdt
        sw_rst_req = 1; wdt_rst_req = 1; tick(); sw_rst_req = 0; wdt_rst_req = 0;
        seen = 0; dones = 0;
        for (int k = 0; k < 40; k++) begin tick(); if (rst_done) dones++; end
        chk("coal_dones", dones, 1);
        chk("coal_cause", rst_cause, 3'b110);

        // async reset during ASSERT with a wdt request pending
        sw_rst_req = 1; tick(); sw_rst_req = 0;
        for (int k = 0; k < 10 && !h2gdma_rst; k++) tick();
        wdt_rst_req = 1; tick(); wdt_rst_req = 0;
        tick();
        #2 gdma_rst_n = 1'b0;
        #1;
        chk("midrst_outs", {dma_stop, h2gdma_rst, rst_busy, rst_done, rst_cause, rst_to}, 8'h00);
        model_reset();
        #1 gdma_rst_n = 1'b1;
        busyn = 0;
        for (int k = 0; k < 30; k++) begin tick(); if (rst_busy) busyn++; end
        chk("midrst_idle", busyn, 0);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            sw_rst_req  = ($urandom_range(0, 19) == 0);
            wdt_rst_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 29) == 0) host_rst_flag = ~host_rst_flag;
            dma_idle = ($urandom_range(0, 3) != 0);
            tick();
        end
        sw_rst_req = 0; wdt_rst_req = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
